data_ram_pipe: RTL and testbench

Parametrised successor to the single-port data RAM used by the load/store stage. It adds configurable width, depth and read latency, byte-lane writes, and a ready/valid request handshake. It also adds a post-reset clear sequencer and error reporting for conflicting or out-of-range requests. It sits between the memory-stage control (MemRead/MemWrite) and the writeback mux.

---
 rtl/data_ram_pipe_if.sv | 28 ++
 rtl/data_ram_pipe.sv | 131 +++++++++++++
 tb/tb_data_ram_pipe.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_pipe_if.sv
// Request/response bundle between memory-stage control and the data RAM.
// Handshake: a request is taken on a rising edge where req_ready=1 and exactly one of MemRead/MemWrite is high.
// read_valid, err_conflict and err_range are single-cycle pulses that are never back-pressured.
interface data_ram_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
);
  logic                 MemRead;
  logic                 MemWrite;
  logic [ADDR_W-1:0]    mem_index;
  logic [WIDTH-1:0]     write_value;
  logic [WIDTH/8-1:0]   byte_en;
  logic                 req_ready;
  logic [WIDTH-1:0]     read_value;
  logic                 read_valid;
  logic                 err_conflict;
  logic                 err_range;

  modport master (
    output MemRead, MemWrite, mem_index, write_value, byte_en,
    input  req_ready, read_value, read_valid, err_conflict, err_range
  );

  modport slave (
    input  MemRead, MemWrite, mem_index, write_value, byte_en,
    output req_ready, read_value, read_valid, err_conflict, err_range
  );
endinterface

// File: rtl/data_ram_pipe.sv
// Single-port data RAM with byte-lane writes, a LATENCY-stage read pipeline,
// an optional post-reset zeroing sweep and pulsed error flags.
module data_ram_pipe #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8,
  parameter int LATENCY    = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  data_ram_pipe_if.slave   bus,
  output logic             o_dbg_state
);

  localparam int LANES = WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [IDX_W-1:0]    r_clr_idx;
  logic [IDX_W-1:0]    w_clr_idx_nxt;
  logic                w_clr_we;
  logic                r_req_ready;

  logic [WIDTH-1:0]    r_mem [DEPTH];

  logic                w_in_range;
  logic [IDX_W-1:0]    w_idx;
  logic                w_rd_acc;
  logic                w_wr_acc;
  logic                w_conflict;

  logic [WIDTH-1:0]    r_rd_data [LATENCY];
  logic [LATENCY-1:0]  r_rd_vld;
  logic                r_err_conflict;
  logic                r_err_range;

  // The extra top bit lets DEPTH == 2**ADDR_W compare without overflow.
  assign w_in_range = ({1'b0, bus.mem_index} < (ADDR_W+1)'(DEPTH));
  assign w_idx      = w_in_range ? bus.mem_index[IDX_W-1:0] : '0;
  assign w_rd_acc   = r_req_ready &  bus.MemRead & ~bus.MemWrite;
  assign w_wr_acc   = r_req_ready & ~bus.MemRead &  bus.MemWrite;
  assign w_conflict = r_req_ready &  bus.MemRead &  bus.MemWrite;

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_clr_we      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_idx == IDX_W'(DEPTH - 1)) begin
          w_state_nxt   = ST_READY;
          w_clr_idx_nxt = '0;
        end else begin
          w_clr_idx_nxt = r_clr_idx + IDX_W'(1);
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_READY;
      end
    endcase
  end

  // req_ready is registered so it is low in reset even when no clear sweep runs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      r_clr_idx   <= '0;
      r_req_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_idx   <= w_clr_idx_nxt;
      r_req_ready <= (w_state_nxt == ST_READY);
    end
  end

  always_ff @(posedge CLK) begin
    if (w_clr_we) begin
      r_mem[r_clr_idx] <= '0;
    end else if (w_wr_acc && w_in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.byte_en[i]) begin
          r_mem[w_idx][8*i +: 8] <= bus.write_value[8*i +: 8];
        end
      end
    end
  end

  // Data stages only advance behind a valid, so the last stage holds the last returned word.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_rd_data[s] <= '0;
      end
      r_rd_vld       <= '0;
      r_err_conflict <= 1'b0;
      r_err_range    <= 1'b0;
    end else begin
      r_rd_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data[0] <= w_in_range ? r_mem[w_idx] : '0;
      end
      for (int s = 1; s < LATENCY; s++) begin
        r_rd_vld[s] <= r_rd_vld[s-1];
        if (r_rd_vld[s-1]) begin
          r_rd_data[s] <= r_rd_data[s-1];
        end
      end
      r_err_conflict <= w_conflict;
      r_err_range    <= (w_rd_acc | w_wr_acc) & ~w_in_range;
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.read_value   = r_rd_data[LATENCY-1];
  assign bus.read_valid   = r_rd_vld[LATENCY-1];
  assign bus.err_conflict = r_err_conflict;
  assign bus.err_range    = r_err_range;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_data_ram_pipe.sv
// Randomised scoreboard bench for data_ram_pipe: a word-array reference model feeds
// expected read data and error pulses into queues that a negedge monitor drains.
module tb_data_ram_pipe;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 200;
  localparam int ADDR_W  = 8;
  localparam int LATENCY = 3;
  localparam int LANES   = WIDTH / 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  data_ram_pipe_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();
  logic dbg_state;

  data_ram_pipe #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY), .INIT_CLEAR(1)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               exp_cyc_q[$];
  logic [1:0]       flag_q[$];
  int               flag_cyc_q[$];
  logic [WIDTH-1:0] model_mem [DEPTH];
  logic [WIDTH-1:0] last_exp = '0;
  bit               mon_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.mem_index   = '0;
    bus.write_value = '0;
    bus.byte_en     = '0;
  endtask

  // Drives one cycle of request and records what the specification says must follow.
  task automatic do_req(input bit rd, input bit wr, input logic [ADDR_W-1:0] idx,
                        input logic [WIDTH-1:0] val, input logic [LANES-1:0] be);
    int               acc_cyc;
    int               ix;
    bit               in_range;
    logic [WIDTH-1:0] mask;
    @(negedge clk);
    bus.MemRead     = rd;
    bus.MemWrite    = wr;
    bus.mem_index   = idx;
    bus.write_value = val;
    bus.byte_en     = be;
    acc_cyc  = cyc + 1;
    ix       = int'(idx);
    in_range = (ix < DEPTH);
    if (rd && wr) begin
      flag_q.push_back(2'b10);
      flag_cyc_q.push_back(acc_cyc);
    end else if (rd || wr) begin
      if (!in_range) begin
        flag_q.push_back(2'b01);
        flag_cyc_q.push_back(acc_cyc);
      end
      if (wr && in_range) begin
        mask = '0;
        for (int l = 0; l < LANES; l++) begin
          if (be[l]) mask[8*l +: 8] = 8'hFF;
        end
        model_mem[ix] = (model_mem[ix] & ~mask) | (val & mask);
      end
      if (rd) begin
        exp_q.push_back(in_range ? model_mem[ix] : '0);
        exp_cyc_q.push_back(acc_cyc + LATENCY - 1);
      end
    end
  endtask

  task automatic end_ops();
    @(negedge clk);
    drive_idle();
  endtask

  // Waits for req_ready while throwing junk requests that must be ignored.
  task automatic wait_ready();
    int rel;
    bit seen;
    rel  = cyc;
    seen = 1'b0;
    for (int k = 0; k < DEPTH + 20; k++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        seen = 1'b1;
        break;
      end
      bus.MemRead     = 1'($urandom_range(0, 1));
      bus.MemWrite    = 1'($urandom_range(0, 1));
      bus.mem_index   = ADDR_W'($urandom_range(0, 255));
      bus.write_value = WIDTH'($urandom);
      bus.byte_en     = LANES'($urandom_range(0, 3));
    end
    drive_idle();
    chk("ready_seen", 32'(seen), 32'(1));
    chk("clear_cycles", 32'(cyc - rel), 32'(DEPTH));
  endtask

  task automatic reset_pulse(input int low_cycles);
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
    chk("rst_read_valid", 32'(bus.read_valid), 32'(0));
    chk("rst_read_value", 32'(bus.read_value), 32'(0));
    chk("rst_err_conflict", 32'(bus.err_conflict), 32'(0));
    chk("rst_err_range", 32'(bus.err_range), 32'(0));
    exp_q.delete();
    exp_cyc_q.delete();
    flag_q.delete();
    flag_cyc_q.delete();
    last_exp = '0;
    repeat (low_cycles) @(negedge clk);
    rst_n = 1'b1;
    wait_ready();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // ---------------- monitor ----------------
  logic             mon_exp_v;
  logic [WIDTH-1:0] mon_d;
  logic [1:0]       mon_ef;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      mon_exp_v = (exp_cyc_q.size() > 0) && (exp_cyc_q[0] == cyc);
      chk("rd_valid", 32'(bus.read_valid), 32'(mon_exp_v));
      if (bus.read_valid && exp_q.size() > 0) begin
        mon_d = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        chk("rd_data", 32'(bus.read_value), 32'(mon_d));
        last_exp = mon_d;
      end else if (!bus.read_valid) begin
        if (mon_exp_v) begin
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
        chk("rd_hold", 32'(bus.read_value), 32'(last_exp));
      end
      mon_ef = 2'b00;
      if (flag_cyc_q.size() > 0 && flag_cyc_q[0] == cyc) begin
        mon_ef = flag_q.pop_front();
        void'(flag_cyc_q.pop_front());
      end
      chk("err_flags", 32'({bus.err_conflict, bus.err_range}), 32'(mon_ef));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int op;
    logic [ADDR_W-1:0] ridx;
    drive_idle();
    reset_pulse(3);
    mon_en = 1'b1;

    // fresh memory reads as zero, including the last word
    for (int i = 0; i < 16; i++) do_req(1'b1, 1'b0, ADDR_W'(i), '0, '0);
    do_req(1'b1, 1'b0, 8'd199, '0, '0);

    // byte-lane merge
    do_req(1'b0, 1'b1, 8'd5, 16'hBEEF, 2'b11);
    do_req(1'b0, 1'b1, 8'd5, 16'h1234, 2'b01);
    do_req(1'b1, 1'b0, 8'd5, '0, '0);
    do_req(1'b0, 1'b1, 8'd9, 16'hFFFF, 2'b00);
    do_req(1'b1, 1'b0, 8'd9, '0, '0);

    // back-to-back reads after writes
    do_req(1'b0, 1'b1, 8'd1, 16'h0011, 2'b11);
    do_req(1'b0, 1'b1, 8'd2, 16'h0022, 2'b11);
    do_req(1'b0, 1'b1, 8'd3, 16'h0033, 2'b11);
    do_req(1'b1, 1'b0, 8'd1, '0, '0);
    do_req(1'b1, 1'b0, 8'd2, '0, '0);
    do_req(1'b1, 1'b0, 8'd3, '0, '0);

    // conflict leaves the word intact
    do_req(1'b0, 1'b1, 8'd7, 16'h005A, 2'b11);
    do_req(1'b1, 1'b1, 8'd7, 16'h00FF, 2'b11);
    do_req(1'b1, 1'b0, 8'd7, '0, '0);

    // out-of-range edges
    do_req(1'b0, 1'b1, 8'd199, 16'hABCD, 2'b11);
    do_req(1'b0, 1'b1, 8'd210, 16'h0077, 2'b11);
    do_req(1'b1, 1'b0, 8'd210, '0, '0);
    do_req(1'b1, 1'b0, 8'd199, '0, '0);
    do_req(1'b1, 1'b0, 8'd200, '0, '0);
    do_req(1'b0, 1'b1, 8'd255, 16'h5555, 2'b11);
    do_req(1'b0, 1'b0, 8'd4, 16'h9999, 2'b11);

    // random mix with read-after-write locality
    for (int n = 0; n < 400; n++) begin
      op   = $urandom_range(0, 9);
      ridx = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 255))
                                         : ADDR_W'($urandom_range(190, 205));
      if ($urandom_range(0, 1) == 0) ridx = ADDR_W'($urandom_range(0, 15));
      if (op <= 1)      do_req(1'b0, 1'b0, ridx, WIDTH'($urandom), LANES'($urandom_range(0, 3)));
      else if (op <= 4) do_req(1'b0, 1'b1, ridx, WIDTH'($urandom), LANES'($urandom_range(0, 3)));
      else if (op <= 8) do_req(1'b1, 1'b0, ridx, WIDTH'($urandom), LANES'($urandom_range(0, 3)));
      else              do_req(1'b1, 1'b1, ridx, WIDTH'($urandom), LANES'($urandom_range(0, 3)));
    end

    // reset with two reads in flight: nothing may emerge and the sweep restarts
    do_req(1'b1, 1'b0, 8'd1, '0, '0);
    do_req(1'b1, 1'b0, 8'd2, '0, '0);
    reset_pulse(1);
    for (int i = 0; i < 4; i++) do_req(1'b1, 1'b0, ADDR_W'(i), '0, '0);
    do_req(1'b1, 1'b0, 8'd5, '0, '0);
    do_req(1'b1, 1'b0, 8'd199, '0, '0);
    for (int n = 0; n < 60; n++) begin
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ADDR_W'($urandom_range(0, 15)), WIDTH'($urandom), LANES'($urandom_range(0, 3)));
    end
    end_ops();

    for (int k = 0; k < LATENCY + 10; k++) begin
      if (exp_q.size() == 0 && flag_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("drain_reads", 32'(exp_q.size()), 32'(0));
    chk("drain_flags", 32'(flag_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
